// File: rtl/nios_pulse_out_port.sv
// nios_pulse_out_port - Avalon-MM output PIO with atomic SET/CLEAR and a hardware one-shot pulse group.
module nios_pulse_out_port #(
   parameter int unsigned         WIDTH       = 8,
   parameter int unsigned         CNT_W       = 16,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   typedef enum logic {IDLE, PULSE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   data_reg, data_nxt;
   logic [WIDTH-1:0]   pulse_mask, mask_nxt;
   logic [31:0]        rd_nxt;

   logic               wr;
   logic [WIDTH-1:0]   wd;
   logic [CNT_W-1:0]   wd_len;
   logic               pulse_ok;
   logic               clear_wr;

   assign wr       = chipselect & ~write_n;
   assign wd       = writedata[WIDTH-1:0];
   assign wd_len   = writedata[16+CNT_W-1:16];
   assign pulse_ok = wr && (address == 2'd3) && (wd_len != '0) && (wd != '0);
   assign clear_wr = wr && (address == 2'd2);
   assign out_port = data_reg | pulse_mask;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         data_reg   <= RESET_VALUE;
         pulse_mask <= '0;
         readdata   <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         data_reg   <= data_nxt;
         pulse_mask <= mask_nxt;
         readdata   <= rd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      data_nxt  = data_reg;
      mask_nxt  = pulse_mask;

      if (wr) begin
         case (address)
            2'd0:    data_nxt = wd;
            2'd1:    data_nxt = data_reg | wd;
            2'd2: begin
               data_nxt = data_reg & ~wd;
               mask_nxt = pulse_mask & ~wd;
            end
            default: ;
         endcase
      end

      case (state)
         IDLE: begin
            if (pulse_ok) begin
               mask_nxt  = wd;
               cnt_nxt   = wd_len;
               state_nxt = PULSE;
            end
         end
         PULSE: begin
            // A retrigger beats expiry in the same cycle, so a chained pulse has no gap.
            if (pulse_ok) begin
               mask_nxt = pulse_mask | wd;
               cnt_nxt  = wd_len;
            end else if ((clear_wr && ((pulse_mask & ~wd) == '0)) || (cnt == CNT_W'(1))) begin
               mask_nxt  = '0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_nxt = '0;
      case (address)
         2'd0: rd_nxt[WIDTH-1:0] = data_reg;
         2'd1: rd_nxt[WIDTH-1:0] = out_port;
         2'd2: rd_nxt[WIDTH-1:0] = pulse_mask;
         default: begin
            rd_nxt[WIDTH-1:0]     = pulse_mask;
            rd_nxt[16+CNT_W-1:16] = cnt;
         end
      endcase
   end

endmodule

// File: tb/tb_nios_pulse_out_port.sv
// tb/tb_nios_pulse_out_port.sv - directed self-checking bench for nios_pulse_out_port.
module tb_nios_pulse_out_port;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_pass = 0;
   int n_total = 0;

   nios_pulse_out_port #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'hA5)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Called at a negedge; the write is sampled at the following posedge.
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (2) @(negedge clk);

      // 1: reset state and data read
      check("rst_out", {24'h0, out_port}, 32'hA5);
      check("rst_rd", readdata, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rd_data_a5", readdata, 32'hA5);

      // 2: DATA / SET / CLEAR
      bus_wr(2'd0, 32'h0F);
      check("data_0f", {24'h0, out_port}, 32'h0F);
      bus_wr(2'd1, 32'h30);
      check("set_3f", {24'h0, out_port}, 32'h3F);
      bus_wr(2'd2, 32'h03);
      check("clr_3c", {24'h0, out_port}, 32'h3C);
      address = 2'd1;
      @(negedge clk);
      check("rd_out_3c", readdata, 32'h3C);

      // 3: single pulse, len 5
      bus_wr(2'd0, 32'h0);
      bus_wr(2'd3, 32'h0005_0081);
      for (int k = 0; k <= 5; k++) begin
         check($sformatf("p5_out_%0d", k), {24'h0, out_port}, (k < 5) ? 32'h81 : 32'h0);
         if (k >= 1)
            check($sformatf("p5_rd_%0d", k), readdata, {16'(6 - k), 16'h0081});
         @(negedge clk);
      end
      check("p5_rd_idle", readdata, 32'h0);

      // 4: retrigger exactly at cnt==1, then invalid writes
      bus_wr(2'd3, 32'h000A_0001);
      repeat (9) @(negedge clk);
      check("rt_last", {24'h0, out_port}, 32'h01);
      bus_wr(2'd3, 32'h0003_0002);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rt_out_%0d", k), {24'h0, out_port}, (k < 3) ? 32'h03 : 32'h0);
         @(negedge clk);
      end
      bus_wr(2'd3, 32'h0000_0005);
      check("len0_out", {24'h0, out_port}, 32'h0);
      bus_wr(2'd3, 32'h0005_0000);
      check("mask0_out", {24'h0, out_port}, 32'h0);
      @(negedge clk);
      check("inv_rd3", readdata, 32'h0);

      // 5: CLEAR during a long pulse
      bus_wr(2'd0, 32'h40);
      bus_wr(2'd3, 32'h0064_000C);
      check("cl_start", {24'h0, out_port}, 32'h4C);
      bus_wr(2'd2, 32'h04);
      check("cl_part", {24'h0, out_port}, 32'h48);
      @(negedge clk);
      check("cl_rd_mask", readdata, 32'h08);
      bus_wr(2'd2, 32'h08);
      check("cl_all", {24'h0, out_port}, 32'h40);
      address = 2'd3;
      @(negedge clk);
      check("cl_rd3", readdata, 32'h0);

      // 6: reset mid-pulse
      bus_wr(2'd0, 32'h11);
      bus_wr(2'd3, 32'h0064_0022);
      check("mr_pulse", {24'h0, out_port}, 32'h33);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mr_out", {24'h0, out_port}, 32'hA5);
      check("mr_rd", readdata, 32'h0);
      @(negedge clk);
      check("mr_rd3", readdata, 32'h0);
      repeat (3) @(negedge clk);
      check("mr_stay", {24'h0, out_port}, 32'hA5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
